// File: rtl/tmr_arb.sv
// tmr_arb: one down-counting interval timer shared by N_REQ requesters.
// An arbiter hands the timer to one requester at a time. The winner's interval
// is latched and counted down on tick strobes, and the winner's done bit is
// pulsed for one cycle at expiry.
// Build option: define TMR_ARB_FIXED_PRIO_EN to use fixed priority instead of
// round-robin. With fixed priority the lowest requesting index always wins.
// Ports and timing are the same in both modes.
module tmr_arb #(
  parameter  int N_REQ = 4,
  parameter  int CW    = 8,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               aclr_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*CW-1:0] len,
  input  logic               tick,
  input  logic               abort,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic [CW-1:0]      cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [N_REQ-1:0]       gnt_q, gnt_d;
  logic [N_REQ-1:0]       done_q, done_d;
  // Index of the most recent grant. It is both the round-robin pointer and
  // the current owner while a grant is active.
  logic [IW-1:0]          last_q, last_d;

  logic [N_REQ-1:0][CW-1:0] len_v;
  logic                   sel_found;
  logic [IW-1:0]          sel_idx;
  logic [CW-1:0]          sel_len;
  logic [N_REQ-1:0]       sel_oh;
  logic                   owner_req;

  // Split the flat length bus into one lane per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_len
    assign len_v[g] = len[g*CW +: CW];
  end

`ifdef TMR_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest requesting index wins. The reverse scan leaves
  // the lowest index as the final assignment.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (req[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] scan;

  // Round-robin: scan upward from last+1 with wrap. The first requester found wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan      = last_q;
    for (int k = 0; k < N_REQ; k++) begin
      scan = (scan == IW'(N_REQ-1)) ? '0 : scan + IW'(1);
      if (!sel_found && req[scan]) begin
        sel_found = 1'b1;
        sel_idx   = scan;
      end
    end
  end
`endif

  assign sel_len   = len_v[sel_idx];
  assign sel_oh    = sel_found ? (N_REQ'(1) << sel_idx) : '0;
  assign owner_req = req[last_q];

  // Next-state logic. In RUN, an abort or withdraw takes priority over the
  // final tick, so a cancelled interval never produces a done pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        cnt_d = '0;
        if (sel_found) begin
          gnt_d  = sel_oh;
          cnt_d  = sel_len;
          last_d = sel_idx;
          if (sel_len == '0) begin
            // A zero-length interval expires immediately. Skip RUN.
            state_d = S_DONE;
            done_d  = sel_oh;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort || !owner_req) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
            done_d  = gnt_q;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_DONE: begin
        // Stay here for one cycle only, then release the timer.
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers. The pointer resets to N_REQ-1 so requester 0 is first
  // in the round-robin order.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      last_q  <= IW'(N_REQ-1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign cnt  = cnt_q;
  assign busy = (state_q == S_RUN) || (state_q == S_DONE);

endmodule

// File: tb/tb_tmr_arb.sv
// Bench for tmr_arb with N_REQ=4 and CW=8. Directed scenarios check fixed
// expected values. A randomized run compares every cycle against a
// behavioural model that tracks the owner, the remaining ticks and a pending
// done flag.
module tb_tmr_arb;
  logic        clk = 1'b0;
  logic        aclr_n;
  logic [3:0]  req;
  logic [31:0] len;
  logic        tick, abort;
  logic [3:0]  gnt, done;
  logic        busy;
  logic [7:0]  cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] lv [4];

  // Model state: owner (-1 = none), remaining ticks, done pending, last winner.
  int m_owner, m_rem, m_last;
  bit m_done;

  tmr_arb #(.N_REQ(4), .CW(8)) dut (
    .clk(clk), .aclr_n(aclr_n), .req(req), .len(len), .tick(tick),
    .abort(abort), .gnt(gnt), .done(done), .busy(busy), .cnt(cnt)
  );

  always #5 clk = ~clk;

  function automatic void set_len();
    len = {lv[3], lv[2], lv[1], lv[0]};
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_rem = 0; m_last = 3; m_done = 0;
  endfunction

  function automatic void model_step();
    if (m_done) begin
      m_done = 0; m_owner = -1; m_rem = 0;
    end else if (m_owner >= 0) begin
      if (abort || !req[m_owner[1:0]]) begin
        m_owner = -1; m_rem = 0;
      end else if (tick) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_done = 1;
      end
    end else if (req != 4'b0000) begin
      int c;
      c = -1;
`ifdef TMR_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) if (c < 0 && req[i]) c = i;
`else
      for (int k = 1; k <= 4; k++) begin
        int j;
        j = (m_last + k) % 4;
        if (c < 0 && req[j[1:0]]) c = j;
      end
`endif
      m_owner = c; m_last = c; m_rem = int'(lv[c]); m_done = (m_rem == 0);
    end
  endfunction

  // Advance one clock and update the model. Outputs are sampled 1 time unit
  // after the edge.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    aclr_n = 1'b0; req = '0; tick = 1'b0; abort = 1'b0;
    for (int i = 0; i < 4; i++) lv[i] = 8'd0;
    set_len();
    @(negedge clk);
    @(negedge clk);
    aclr_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    aclr_n = 1'b0; req = '0; tick = 1'b0; abort = 1'b0;
    for (int i = 0; i < 4; i++) lv[i] = 8'd0;
    set_len();
    #1;
    checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_init: gnt=%b done=%b busy=%b cnt=%0d want 0/0/0/0", gnt, done, busy, cnt);
    end
    do_reset();
    req = 4'b0001; lv[0] = 8'd5; set_len();
    step();
    checks++;
    if (gnt !== 4'b0001 || cnt !== 8'd5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_run_setup: gnt=%b cnt=%0d busy=%b want 0001/5/1", gnt, cnt, busy);
    end
    #2 aclr_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_async: gnt=%b done=%b busy=%b cnt=%0d want 0/0/0/0", gnt, done, busy, cnt);
    end
    @(negedge clk);
    aclr_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) lv[i] = 8'd3;
    set_len();
    step();
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant: gnt=%b want 0001", gnt);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_c [3];
    exp_c = '{8'd3, 8'd2, 8'd1};
    do_reset();
    req = 4'b0100; lv[2] = 8'd3; set_len(); tick = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (gnt !== 4'b0100 || cnt !== exp_c[c] || done !== 4'b0) begin
        failures++;
        $display("FAIL single_c%0d: gnt=%b cnt=%0d done=%b want 0100/%0d/0000", c+1, gnt, cnt, done, exp_c[c]);
      end
    end
    step();
    checks++;
    if (done !== 4'b0100 || cnt !== 8'd0 || gnt !== 4'b0100 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_done: done=%b cnt=%0d gnt=%b busy=%b want 0100/0/0100/1", done, cnt, gnt, busy);
    end
    req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_release: gnt=%b done=%b busy=%b want 0/0/0", gnt, done, busy);
    end
  endtask

  // Drive a held request pattern with len=1 and check the owner of five
  // successive grants.
  task automatic test_rotation(input logic [3:0] r, input logic [3:0] order [5], input string nm);
    do_reset();
    req = r; tick = 1'b1;
    for (int i = 0; i < 4; i++) lv[i] = 8'd1;
    set_len();
    for (int g = 0; g < 5; g++) begin
      step();
      checks++;
      if (gnt !== order[g] || done !== 4'b0) begin
        failures++;
        $display("FAIL %s_gnt%0d: gnt=%b done=%b want %b/0000", nm, g, gnt, done, order[g]);
      end
      step();
      checks++;
      if (done !== order[g] || gnt !== order[g]) begin
        failures++;
        $display("FAIL %s_done%0d: done=%b gnt=%b want %b", nm, g, done, gnt, order[g]);
      end
      step();
      checks++;
      if (gnt !== 4'b0 || done !== 4'b0) begin
        failures++;
        $display("FAIL %s_gap%0d: gnt=%b done=%b want 0/0", nm, g, gnt, done);
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_rr_order();
    logic [3:0] o [5];
`ifdef TMR_ARB_FIXED_PRIO_EN
    o = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    o = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    test_rotation(4'b1111, o, "rr_all");
  endtask

  task automatic test_pair();
    logic [3:0] o [5];
`ifdef TMR_ARB_FIXED_PRIO_EN
    o = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
`else
    o = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};
`endif
    test_rotation(4'b1010, o, "pair");
  endtask

  task automatic test_zero_len_and_hold();
    do_reset();
    req = 4'b0010; lv[1] = 8'd0; set_len(); tick = 1'b0;
    step();
    checks++;
    if (gnt !== 4'b0010 || done !== 4'b0010 || busy !== 1'b1 || cnt !== 8'd0) begin
      failures++;
      $display("FAIL zero_len: gnt=%b done=%b busy=%b cnt=%0d want 0010/0010/1/0", gnt, done, busy, cnt);
    end
    req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_idle: gnt=%b done=%b busy=%b want 0/0/0", gnt, done, busy);
    end
    req = 4'b0010; lv[1] = 8'd2; set_len();
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (gnt !== 4'b0010 || cnt !== 8'd2 || done !== 4'b0) begin
        failures++;
        $display("FAIL hold_c%0d: gnt=%b cnt=%0d done=%b want 0010/2/0000", c, gnt, cnt, done);
      end
    end
    // The latched length ignores later changes to len.
    lv[1] = 8'd9; set_len(); tick = 1'b1;
    step();
    checks++;
    if (cnt !== 8'd1) begin
      failures++;
      $display("FAIL hold_tick: cnt=%0d want 1", cnt);
    end
    step();
    checks++;
    if (done !== 4'b0010 || cnt !== 8'd0) begin
      failures++;
      $display("FAIL hold_done: done=%b cnt=%0d want 0010/0", done, cnt);
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_abort_withdraw();
    do_reset();
    req = 4'b0001; lv[0] = 8'd8; lv[1] = 8'd2; set_len(); tick = 1'b1;
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (cnt !== 8'd5 || gnt !== 4'b0001) begin
      failures++;
      $display("FAIL abort_setup: cnt=%0d gnt=%b want 5/0001", cnt, gnt);
    end
    abort = 1'b1;
    step();
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0 || done !== 4'b0 || cnt !== 8'd0) begin
      failures++;
      $display("FAIL abort: gnt=%b busy=%b done=%b cnt=%0d want 0/0/0/0", gnt, busy, done, cnt);
    end
    abort = 1'b0; req = 4'b0000;
    step();
    checks++;
    if (done !== 4'b0 || gnt !== 4'b0) begin
      failures++;
      $display("FAIL abort_after: done=%b gnt=%b want 0/0", done, gnt);
    end
    req = 4'b0010;
    step();
    step();
    checks++;
    if (gnt !== 4'b0010 || cnt !== 8'd1) begin
      failures++;
      $display("FAIL withdraw_setup: gnt=%b cnt=%0d want 0010/1", gnt, cnt);
    end
    req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || cnt !== 8'd0) begin
      failures++;
      $display("FAIL withdraw_final_tick: gnt=%b done=%b busy=%b cnt=%0d want 0/0/0/0", gnt, done, busy, cnt);
    end
    step();
    checks++;
    if (done !== 4'b0) begin
      failures++;
      $display("FAIL withdraw_after: done=%b want 0000", done);
    end
  endtask

  task automatic test_random();
    logic [3:0] eg;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) req = req ^ 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 2) == 0) lv[i] = 8'($urandom_range(0, 6));
      set_len();
      tick  = ($urandom_range(0, 9) < 7);
      abort = ($urandom_range(0, 19) == 0);
      step();
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      checks++;
      if (gnt !== eg || done !== (m_done ? eg : 4'b0000) || busy !== (m_owner >= 0) || cnt !== 8'(m_rem)) begin
        failures++;
        $display("FAIL random_cyc%0d: gnt=%b done=%b busy=%b cnt=%0d want %b/%b/%0d/%0d",
                 n, gnt, done, busy, cnt, eg, (m_done ? eg : 4'b0000), (m_owner >= 0), m_rem);
      end
    end
    abort = 1'b0; req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_pair();
    test_zero_len_and_hold();
    test_abort_withdraw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
